// File: rtl/adat_rx_pkg.sv
// Shared types and default sizing for the ADAT receive interval decoder.
package adat_rx_pkg;

    localparam int TIME_W      = 12;
    localparam int MAX_BITS    = 5;
    localparam int FRAME_SHIFT = 8;

    // Length of the ADAT sync gap in zero cells; the upstream mask covers it.
    localparam int SYNC_ZEROS  = 10;

    typedef logic [MAX_BITS-1:0] bit_run_t;
    typedef logic [2:0]          bit_cnt_t;

endpackage

// File: rtl/adat_rx_interval_quantizer.sv
// Combinational quantizer: turns an edge-to-edge interval into a cell count.
// Thresholds sit at odd half-cells, so comparing against each one gives
// round-to-nearest with ties rounding up.
module adat_rx_interval_quantizer
    import adat_rx_pkg::*;
#(
    parameter int TIME_W      = adat_rx_pkg::TIME_W,
    parameter int MAX_BITS    = adat_rx_pkg::MAX_BITS,
    parameter int FRAME_SHIFT = adat_rx_pkg::FRAME_SHIFT
) (
    input  logic [TIME_W-1:0] i_edge_time,
    input  logic [TIME_W-1:0] i_frame_time,
    output bit_cnt_t          o_n,
    output logic              o_overrun
);

    localparam int TH_W = TIME_W + 3;
    // 11x frame time needs one bit more than the threshold width before the shift.
    localparam int PW   = TIME_W + 4;

    logic [TH_W-1:0] th [MAX_BITS+1];
    logic [MAX_BITS:0] ge;

    for (genvar k = 0; k <= MAX_BITS; k++) begin : g_th
        assign th[k] = TH_W'((PW'(2 * k + 1) * PW'(i_frame_time)) >> FRAME_SHIFT);
        assign ge[k] = ({3'b000, i_edge_time} >= th[k]);
    end

    // Count thresholds passed; only MAX_BITS are counted, so n saturates naturally.
    always_comb begin
        o_n = '0;
        for (int k = 0; k < MAX_BITS; k++) begin
            o_n = o_n + {2'b00, ge[k]};
        end
        o_overrun = ge[MAX_BITS];
    end

endmodule

// File: rtl/adat_rx_interval_decoder.sv
// ADAT NRZI interval decoder: one decoded run (n-1 zeros then a one) per
// accepted edge, registered with one cycle of latency.
// Optional macro ADAT_RX_BIT_DECODER_ERR_EN adds o_err, a one-cycle pulse for
// overrun intervals and glitches seen while decoding is enabled.
module adat_rx_interval_decoder
    import adat_rx_pkg::*;
#(
    parameter int TIME_W      = adat_rx_pkg::TIME_W,
    parameter int MAX_BITS    = adat_rx_pkg::MAX_BITS,
    parameter int FRAME_SHIFT = adat_rx_pkg::FRAME_SHIFT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_edge,
    input  logic [TIME_W-1:0]   i_edge_time,
    input  logic [TIME_W-1:0]   i_frame_time,
    input  logic                i_sync_mask,
    output logic [MAX_BITS-1:0] o_bits,
    output bit_cnt_t            o_bit_count,
`ifdef ADAT_RX_BIT_DECODER_ERR_EN
    output logic                o_err,
`endif
    output logic                o_valid
);

    bit_cnt_t n;
    logic     overrun;
    logic     accept;
    logic     fire;

    adat_rx_interval_quantizer #(
        .TIME_W      (TIME_W),
        .MAX_BITS    (MAX_BITS),
        .FRAME_SHIFT (FRAME_SHIFT)
    ) u_quant (
        .i_edge_time  (i_edge_time),
        .i_frame_time (i_frame_time),
        .o_n          (n),
        .o_overrun    (overrun)
    );

    assign accept = i_edge & i_sync_mask;
    assign fire   = accept & (n != '0);

    // Output registers: new run on an accepted edge, otherwise hold with valid low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_bits      <= '0;
            o_bit_count <= '0;
        end else begin
            o_valid <= fire;
            if (fire) begin
                // Newest bit is the one at bit 0; the preceding n-1 cells are zeros.
                o_bits      <= MAX_BITS'(1);
                o_bit_count <= n;
            end
        end
    end

`ifdef ADAT_RX_BIT_DECODER_ERR_EN
    // Error pulse: interval too long for a data run, or too short to be a cell.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else begin
            o_err <= accept & (overrun | (n == '0));
        end
    end
`else
    logic unused_overrun;
    assign unused_overrun = overrun;
`endif

endmodule

// File: tb/tb_adat_rx_interval_decoder.sv
// Directed bench for adat_rx_interval_decoder.
// With ADAT_RX_BIT_DECODER_ERR_EN defined, o_err is also checked.
module tb_adat_rx_interval_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        edge_in = 1'b0;
    logic [11:0] edge_time = '0;
    logic [11:0] frame_time = '0;
    logic        sync_mask = 1'b0;
    logic [4:0]  bits;
    logic [2:0]  bit_count;
    logic        valid;
`ifdef ADAT_RX_BIT_DECODER_ERR_EN
    logic        err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adat_rx_interval_decoder dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_edge       (edge_in),
        .i_edge_time  (edge_time),
        .i_frame_time (frame_time),
        .i_sync_mask  (sync_mask),
        .o_bits       (bits),
        .o_bit_count  (bit_count),
`ifdef ADAT_RX_BIT_DECODER_ERR_EN
        .o_err        (err),
`endif
        .o_valid      (valid)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input int unsigned t,
                        input int unsigned ft, input logic m);
        @(negedge clk);
        rst        = r;
        edge_in    = e;
        edge_time  = 12'(t);
        frame_time = 12'(ft);
        sync_mask  = m;
        @(posedge clk);
        #1;
        edge_in = 1'b0;
        rst     = 1'b0;
    endtask

    // Check outputs after a step; err_exp is ignored in the default build.
    task automatic expect_out(input string tag, input logic v, input int unsigned cnt,
                              input int unsigned b, input logic err_exp);
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
        check({tag, ".count"}, {5'd0, bit_count}, 8'(cnt));
        check({tag, ".bits"},  {3'd0, bits}, 8'(b));
`ifdef ADAT_RX_BIT_DECODER_ERR_EN
        check({tag, ".err"},   {7'd0, err}, {7'd0, err_exp});
`else
        if (err_exp === 1'bx) $display("unexpected x in err expectation for %s", tag);
`endif
    endtask

    initial begin
        // Reset held two cycles
        step(1, 0, 0, 2048, 1);
        step(1, 0, 0, 2048, 1);
        step(0, 0, 0, 2048, 1);
        expect_out("reset", 0, 0, 0, 0);

        // First run: 17 cycles at T=16 -> one cell
        step(0, 1, 17, 2048, 1);
        expect_out("t17", 1, 1, 1, 0);
        step(0, 0, 0, 2048, 1);
        expect_out("t17_idle", 0, 1, 1, 0);

        // Sync region suppresses output
        step(0, 1, 17, 2048, 0);
        expect_out("mask0_t17", 0, 1, 1, 0);

        // Threshold sweep at frame_time=2048 (th = 8,24,40,56,72; overrun at 88)
        step(0, 1, 8, 2048, 1);
        expect_out("t8", 1, 1, 1, 0);
        step(0, 1, 23, 2048, 1);
        expect_out("t23", 1, 1, 1, 0);
        step(0, 1, 24, 2048, 1);
        expect_out("t24", 1, 2, 1, 0);
        step(0, 1, 40, 2048, 1);
        expect_out("t40", 1, 3, 1, 0);
        step(0, 1, 55, 2048, 1);
        expect_out("t55", 1, 3, 1, 0);
        step(0, 1, 56, 2048, 1);
        expect_out("t56", 1, 4, 1, 0);
        step(0, 1, 72, 2048, 1);
        expect_out("t72", 1, 5, 1, 0);
        // Glitch: no valid, count holds at 5
        step(0, 1, 7, 2048, 1);
        expect_out("t7", 0, 5, 1, 1);
        step(0, 1, 87, 2048, 1);
        expect_out("t87", 1, 5, 1, 0);
        step(0, 1, 88, 2048, 1);
        expect_out("t88", 1, 5, 1, 1);
        step(0, 1, 200, 2048, 1);
        expect_out("t200", 1, 5, 1, 1);

        // Smaller frame: th0=4, th1=12, th2=20
        step(0, 1, 12, 1024, 1);
        expect_out("ft1024_t12", 1, 2, 1, 0);
        step(0, 1, 11, 1024, 1);
        expect_out("ft1024_t11", 1, 1, 1, 0);

        // Zero frame time: every threshold 0, so every edge saturates (and overruns)
        step(0, 1, 0, 0, 1);
        expect_out("ft0", 1, 5, 1, 1);

        // Masked overrun: nothing changes, no error
        step(0, 1, 200, 1024, 0);
        expect_out("mask0_t200", 0, 5, 1, 0);

        // Large frame time exercises wide threshold arithmetic: 4095 -> th4=143, th5=175
        step(0, 1, 143, 4095, 1);
        expect_out("ft4095_t143", 1, 5, 1, 0);
        step(0, 1, 142, 4095, 1);
        expect_out("ft4095_t142", 1, 4, 1, 0);

        // Reset wins over a valid edge in the same cycle
        step(1, 1, 40, 2048, 1);
        expect_out("rst_edge", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adat_rx_interval_decoder.md
Name: adat_rx_interval_decoder

Overview:
- Converts measured NRZI edge-to-edge intervals from the ADAT optical/coax receiver into decoded bit runs.
- Each transition encodes a '1'. An interval of k bit cells means k-1 zeros followed by a one.
- Sits between the edge detector/interval timer (upstream) and the frame deserializer (downstream).
- Decoding is gated off while the sync gap (10 zeros) is being traversed.

Parameters:
- TIME_W, 12, width of the interval and frame-time inputs in i_clk cycles.
- MAX_BITS, 5, longest legal data run (4 zeros + 1). Also the width of o_bits.
- FRAME_SHIFT, 8, threshold divisor exponent: thresholds are ((2k+1)·frame_time) >> FRAME_SHIFT.

Ports:
- i_clk  in  1  sole clock
- i_rst  in  1  synchronous, active-high reset
- i_edge  in  1  single-cycle pulse: an input transition was detected this cycle
- i_edge_time  in  TIME_W  cycles elapsed since the previous edge; valid when i_edge=1
- i_frame_time  in  TIME_W  measured period of 128 bit cells in i_clk cycles; bit cell T = i_frame_time/128
- i_sync_mask  in  1  1 = decoding enabled; 0 = inside sync region, suppress output
- o_bits  out  MAX_BITS  decoded run, LSB-aligned, newest bit at bit 0
- o_bit_count  out  3  number of valid bits in o_bits (1..MAX_BITS)
- o_valid  out  1  one-cycle strobe: o_bits/o_bit_count are new
- o_err  out  1  only with the optional feature compiled in

Behaviour:
- One clock i_clk; reset is synchronous and active-high. Port names are i_clk and i_rst.
- Reset (priority over everything): o_bits=0, o_bit_count=0, o_valid=0, o_err=0.
- Thresholds are combinational from i_frame_time, each TIME_W+3 bits wide, no overflow: th_k = ((2k+1)·i_frame_time) >> FRAME_SHIFT for k=0..MAX_BITS-1.
  - Example, i_frame_time=2048: th0=8, th1=24, th2=40, th3=56, th4=72.
- Quantization: n = number of thresholds th_k with i_edge_time ≥ th_k.
  - This is round-to-nearest cell count; ties round up.
  - n saturates at MAX_BITS.
  - Raw count > MAX_BITS means the interval is ≥ th_MAX_BITS = (11·i_frame_time)>>8, i.e. ≥ 88 for i_frame_time=2048. This is the overrun condition.
- Registered output, latency 1 cycle. On a rising edge with i_edge=1, i_sync_mask=1 and n≥1:
  - o_valid←1
  - o_bit_count←n
  - o_bits←5'b00001 (run of n-1 zeros above a trailing one; bits above n-1 are zero)
- n=0 (i_edge_time < th0): glitch. No valid, outputs hold.
- i_sync_mask=0: no valid regardless of i_edge. o_bits/o_bit_count hold.
- Any cycle not producing a new run: o_valid←0, o_bits/o_bit_count hold their last value.
- i_frame_time=0: all thresholds 0, so n=MAX_BITS for every edge. This is accepted and not special-cased.
- No internal state beyond the output registers. No FSM.

Optional Feature:
- Macro ADAT_RX_BIT_DECODER_ERR_EN.
- Defined: adds port o_err.
  - Registered one-cycle pulse when i_edge=1 and i_sync_mask=1 with raw count > MAX_BITS, or with n=0.
  - The saturated run is still emitted with o_valid=1.
- Undefined: no o_err port; overruns saturate silently, glitches are dropped silently.

Decomposition:
- Package adat_rx_pkg:
  - TIME_W, MAX_BITS, FRAME_SHIFT defaults
  - SYNC_ZEROS=10
  - typedef bit_run_t (logic [MAX_BITS-1:0])
  - typedef bit_cnt_t (logic [2:0])
- One natural sub-module, adat_rx_interval_quantizer: purely combinational; i_edge_time and i_frame_time in, n and overrun out. The top registers its outputs.

Test Plan:
- i_rst=1 for 2 cycles, then release -> o_valid=0, o_bits=0, o_bit_count=0.
- i_frame_time=2048, i_sync_mask=1, i_edge pulse with i_edge_time=17 -> next cycle o_valid=1, o_bit_count=1, o_bits=5'b00001; following cycle o_valid=0.
- Same setup, i_sync_mask=0, i_edge_time=17 -> o_valid stays 0; o_bit_count stays 1.
- Sweep with i_frame_time=2048: 7→no valid; 8→1; 23→1; 24→2; 40→3; 56→4; 72→5; 87→5; 200→5 (o_err pulses for 7 and 200 when ADAT_RX_BIT_DECODER_ERR_EN is defined).
- i_frame_time=1024 (th0=4, th1=12), i_edge_time=12 -> o_bit_count=2.
- Assert i_rst in the same cycle as a valid i_edge -> o_valid=0 next cycle, outputs at reset values.
